// File: rtl/if_stage_pipeline_if.sv
// Fetch-side bundle between the PC/IF-ID stage, the hazard unit, EX redirect,
// instruction memory and decode.
interface if_stage_pipeline_if #(
    parameter int N = 32
);
    // Control and fetch inputs to the stage
    logic          hazard_hold_i;
    logic          branch_taken_i;
    logic [N-1:0]  branch_target_i;
    logic [31:0]   instr_i;

    // Registered fetch address, IF/ID contents and performance counters
    logic [N-1:0]  pc_o;
    logic [N-1:0]  if_id_pc_o;
    logic [N-1:0]  if_id_pc_plus4_o;
    logic [31:0]   if_id_instr_o;
    logic          if_id_valid_o;
    logic [31:0]   stall_count_o;
    logic [31:0]   flush_count_o;

    // The environment (hazard unit, EX, imem, decode) drives the stage inputs
    modport master (
        output hazard_hold_i,
        output branch_taken_i,
        output branch_target_i,
        output instr_i,
        input  pc_o,
        input  if_id_pc_o,
        input  if_id_pc_plus4_o,
        input  if_id_instr_o,
        input  if_id_valid_o,
        input  stall_count_o,
        input  flush_count_o
    );

    modport slave (
        input  hazard_hold_i,
        input  branch_taken_i,
        input  branch_target_i,
        input  instr_i,
        output pc_o,
        output if_id_pc_o,
        output if_id_pc_plus4_o,
        output if_id_instr_o,
        output if_id_valid_o,
        output stall_count_o,
        output flush_count_o
    );
endinterface

// File: rtl/if_stage_pipeline.sv
// Program counter plus IF/ID pipeline register with hold (load-use) and flush (redirect).
// Optional hold/flush performance counters are built when IF_PERF_COUNTERS_EN is defined.
module if_stage_pipeline #(
    parameter int          N         = 32,
    parameter logic [N-1:0] RESET_PC  = 'h00400000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 reset,
    if_stage_pipeline_if.slave   bus
);

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_HOLD,
        ACT_FLUSH
    } action_e;

    action_e       action;
    logic [N-1:0]  pc_q;
    logic [N-1:0]  pc_plus4;
    logic [N-1:0]  redirect_pc;
    logic [N-1:0]  if_id_pc_q;
    logic [N-1:0]  if_id_pc_plus4_q;
    logic [31:0]   if_id_instr_q;
    logic          if_id_valid_q;

    // Redirect beats a hold request: the held instruction is on the wrong path anyway.
    always_comb begin
        action = ACT_ADVANCE;
        if (bus.branch_taken_i) begin
            action = ACT_FLUSH;
        end else if (bus.hazard_hold_i) begin
            action = ACT_HOLD;
        end
    end

    assign pc_plus4    = pc_q + N'(4);
    assign redirect_pc = bus.branch_target_i & ~N'(3);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            case (action)
                ACT_FLUSH:   pc_q <= redirect_pc;
                ACT_HOLD:    pc_q <= pc_q;
                default:     pc_q <= pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= '0;
            if_id_instr_q    <= NOP_INSTR;
            if_id_valid_q    <= 1'b0;
        end else begin
            case (action)
                ACT_FLUSH: begin
                    if_id_pc_q       <= '0;
                    if_id_pc_plus4_q <= '0;
                    if_id_instr_q    <= NOP_INSTR;
                    if_id_valid_q    <= 1'b0;
                end
                ACT_HOLD: begin
                    if_id_pc_q       <= if_id_pc_q;
                    if_id_pc_plus4_q <= if_id_pc_plus4_q;
                    if_id_instr_q    <= if_id_instr_q;
                    if_id_valid_q    <= if_id_valid_q;
                end
                default: begin
                    if_id_pc_q       <= pc_q;
                    if_id_pc_plus4_q <= pc_plus4;
                    if_id_instr_q    <= bus.instr_i;
                    if_id_valid_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pc_o             = pc_q;
    assign bus.if_id_pc_o       = if_id_pc_q;
    assign bus.if_id_pc_plus4_o = if_id_pc_plus4_q;
    assign bus.if_id_instr_o    = if_id_instr_q;
    assign bus.if_id_valid_o    = if_id_valid_q;

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (action == ACT_HOLD && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (action == ACT_FLUSH && flush_cnt_q != 32'hFFFF_FFFF) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign bus.stall_count_o = stall_cnt_q;
    assign bus.flush_count_o = flush_cnt_q;
`else
    assign bus.stall_count_o = 32'h0;
    assign bus.flush_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage_pipeline.sv
// Self-checking bench for if_stage_pipeline: directed scenarios plus randomized
// hold/flush/advance traffic checked against a behavioural fetch model.
module tb_if_stage_pipeline;

    localparam int          N         = 32;
    localparam logic [31:0] RESET_PC  = 32'h00400000;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int          OBS_W     = 4 * 32 + 1 + 2 * 32;
`ifdef IF_PERF_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    if_stage_pipeline_if #(.N(N)) bus ();

    if_stage_pipeline #(
        .N(N),
        .RESET_PC(RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the architectural fetch state
    logic [31:0] m_pc, m_ipc, m_ip4, m_instr, m_stall, m_flush;
    logic        m_valid;

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_ipc   = 32'h0;
        m_ip4   = 32'h0;
        m_instr = NOP_INSTR;
        m_valid = 1'b0;
        m_stall = 32'h0;
        m_flush = 32'h0;
    endtask

    function automatic logic [OBS_W-1:0] observed();
        return {bus.pc_o, bus.if_id_pc_o, bus.if_id_pc_plus4_o, bus.if_id_instr_o,
                bus.if_id_valid_o, bus.stall_count_o, bus.flush_count_o};
    endfunction

    function automatic logic [OBS_W-1:0] expected();
        logic [31:0] s, f;
        s = CNT_EN ? m_stall : 32'h0;
        f = CNT_EN ? m_flush : 32'h0;
        return {m_pc, m_ipc, m_ip4, m_instr, m_valid, s, f};
    endfunction

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic step(input logic hold, input logic br, input logic [31:0] tgt,
                        input logic [31:0] instr);
        bus.hazard_hold_i   = hold;
        bus.branch_taken_i  = br;
        bus.branch_target_i = tgt;
        bus.instr_i         = instr;
        @(posedge clk);
        #1;
        if (br) begin
            m_pc    = {tgt[31:2], 2'b00};
            m_ipc   = 32'h0;
            m_ip4   = 32'h0;
            m_instr = NOP_INSTR;
            m_valid = 1'b0;
            if (m_flush != 32'hFFFFFFFF) m_flush = m_flush + 1;
        end else if (hold) begin
            if (m_stall != 32'hFFFFFFFF) m_stall = m_stall + 1;
        end else begin
            m_ipc   = m_pc;
            m_ip4   = m_pc + 32'd4;
            m_instr = instr;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic test_reset();
        bus.hazard_hold_i   = 1'b0;
        bus.branch_taken_i  = 1'b0;
        bus.branch_target_i = 32'h0;
        bus.instr_i         = 32'h0;
        reset = 1'b1;
        model_reset();
        #12;
        total++;
        if (observed() !== expected()) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", observed(), expected());
        end
        reset = 1'b0;
    endtask

    task automatic test_advance();
        step(1'b0, 1'b0, 32'h0, 32'hAAAA0001);
        step(1'b0, 1'b0, 32'h0, 32'hBBBB0002);
        step(1'b0, 1'b0, 32'h0, 32'hCCCC0003);
        total++;
        if ({bus.pc_o, bus.if_id_pc_o, bus.if_id_pc_plus4_o, bus.if_id_instr_o, bus.if_id_valid_o}
            !== {32'h0040000C, 32'h00400008, 32'h0040000C, 32'hCCCC0003, 1'b1}) begin
            bad++;
            $display("FAIL advance3 pc=%h ipc=%h ip4=%h instr=%h valid=%b exp pc=0040000c ipc=00400008 ip4=0040000c instr=cccc0003 valid=1",
                     bus.pc_o, bus.if_id_pc_o, bus.if_id_pc_plus4_o, bus.if_id_instr_o, bus.if_id_valid_o);
        end
        total++;
        if (observed() !== expected()) begin
            bad++;
            $display("FAIL advance_model got=%h exp=%h", observed(), expected());
        end
    endtask

    task automatic test_hold();
        logic [128:0] snap;
        logic [31:0]  s0;
        step(1'b0, 1'b0, 32'h0, 32'h12345678);
        snap = {bus.pc_o, bus.if_id_pc_o, bus.if_id_pc_plus4_o, bus.if_id_instr_o, bus.if_id_valid_o};
        s0   = bus.stall_count_o;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, $urandom, $urandom);
            total++;
            if ({bus.pc_o, bus.if_id_pc_o, bus.if_id_pc_plus4_o, bus.if_id_instr_o, bus.if_id_valid_o} !== snap) begin
                bad++;
                $display("FAIL hold_stable cycle=%0d got=%h exp=%h", i,
                         {bus.pc_o, bus.if_id_pc_o, bus.if_id_pc_plus4_o, bus.if_id_instr_o, bus.if_id_valid_o}, snap);
            end
        end
        total++;
        if (bus.stall_count_o - s0 !== (CNT_EN ? 32'd4 : 32'd0)) begin
            bad++;
            $display("FAIL hold_stall_delta got=%0d exp=%0d", bus.stall_count_o - s0, CNT_EN ? 4 : 0);
        end
        step(1'b0, 1'b0, 32'h0, 32'h0BADF00D);
        total++;
        if (observed() !== expected()) begin
            bad++;
            $display("FAIL hold_resume got=%h exp=%h", observed(), expected());
        end
    endtask

    task automatic test_flush();
        step(1'b0, 1'b1, 32'h00400103, 32'hDEADBEEF);
        total++;
        if ({bus.pc_o, bus.if_id_instr_o, bus.if_id_valid_o, bus.if_id_pc_o, bus.if_id_pc_plus4_o}
            !== {32'h00400100, 32'h00000013, 1'b0, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL flush pc=%h instr=%h valid=%b ipc=%h ip4=%h exp pc=00400100 instr=00000013 valid=0 ipc=0 ip4=0",
                     bus.pc_o, bus.if_id_instr_o, bus.if_id_valid_o, bus.if_id_pc_o, bus.if_id_pc_plus4_o);
        end
        total++;
        if (observed() !== expected()) begin
            bad++;
            $display("FAIL flush_model got=%h exp=%h", observed(), expected());
        end
    endtask

    task automatic test_flush_hold();
        logic [31:0] s0, f0;
        step(1'b0, 1'b0, 32'h0, 32'h11110000);
        s0 = bus.stall_count_o;
        f0 = bus.flush_count_o;
        step(1'b1, 1'b1, 32'h00400103, 32'h22220000);
        total++;
        if ({bus.pc_o, bus.if_id_instr_o, bus.if_id_valid_o} !== {32'h00400100, 32'h00000013, 1'b0}) begin
            bad++;
            $display("FAIL flush_hold pc=%h instr=%h valid=%b exp pc=00400100 instr=00000013 valid=0",
                     bus.pc_o, bus.if_id_instr_o, bus.if_id_valid_o);
        end
        total++;
        if ({bus.stall_count_o - s0, bus.flush_count_o - f0} !== {32'd0, CNT_EN ? 32'd1 : 32'd0}) begin
            bad++;
            $display("FAIL flush_hold_counts stall_delta=%0d flush_delta=%0d exp 0 and %0d",
                     bus.stall_count_o - s0, bus.flush_count_o - f0, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 32'hFFFFFFFE, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h5A5A5A5A);
        total++;
        if ({bus.pc_o, bus.if_id_pc_o, bus.if_id_pc_plus4_o, bus.if_id_instr_o}
            !== {32'h0, 32'hFFFFFFFC, 32'h0, 32'h5A5A5A5A}) begin
            bad++;
            $display("FAIL wrap pc=%h ipc=%h ip4=%h instr=%h exp pc=0 ipc=fffffffc ip4=0 instr=5a5a5a5a",
                     bus.pc_o, bus.if_id_pc_o, bus.if_id_pc_plus4_o, bus.if_id_instr_o);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            logic h, b;
            h = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            step(h, b, $urandom, $urandom);
            total++;
            if (observed() !== expected()) begin
                bad++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random step=%0d got=%h exp=%h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        step(1'b0, 1'b0, 32'h0, 32'h77777777);
        step(1'b1, 1'b0, 32'h0, 32'h88888888);
        step(1'b1, 1'b0, 32'h0, 32'h99999999);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (observed() !== expected()) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", observed(), expected());
        end
        @(posedge clk);
        #3;
        total++;
        if (observed() !== expected()) begin
            bad++;
            $display("FAIL reset_held got=%h exp=%h", observed(), expected());
        end
        bus.hazard_hold_i = 1'b0;
        reset = 1'b0;
        step(1'b0, 1'b0, 32'h0, 32'hABCDEF01);
        total++;
        if (observed() !== expected()) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", observed(), expected());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_advance();
        test_hold();
        test_flush();
        test_flush_hold();
        test_wrap();
        test_random();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
